softmax_seq: RTL and testbench

- Parametrised sequencer that streams N vectors ("cases") from a BRAM read port into the softmax engine and writes the results back through a BRAM write port.
- Separate input and output FSMs run concurrently, so case k+1 loads while case k drains.
- Adds start/busy/done control, programmable base addresses, configurable vector length and width, and correct alignment for the 1-cycle BRAM read latency.

---
 rtl/softmax_pkg.sv | 21 ++
 rtl/softmax_seq_addr_gen.sv | 52 +++++
 rtl/softmax_seq.sv | 158 +++++++++++++++
 tb/tb_softmax_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax sequencer: default geometry and FSM state encodings.
package softmax_pkg;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_VEC_LEN = 16;
    localparam int DEF_CASE_W  = 8;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_WAIT_READY,
        IN_SEND
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_WAIT_VALID,
        OUT_RECV
    } out_state_t;

endpackage

// File: rtl/softmax_seq_addr_gen.sv
// Case/beat counter producing base + case*VEC_LEN + beat, wrapping at 2^ADDR_W.
module softmax_seq_addr_gen
    import softmax_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int CASE_W  = DEF_CASE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr,
    output logic [CASE_W-1:0] case_idx,
    output logic              beat_last
);

    localparam int BEAT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int OFF_W  = CASE_W + BEAT_W + 1;

    logic [ADDR_W-1:0] base_q;
    logic [BEAT_W-1:0] beat_q;
    logic [CASE_W-1:0] case_q;
    logic [OFF_W-1:0]  offset;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q <= '0;
            beat_q <= '0;
            case_q <= '0;
        end else if (load) begin
            base_q <= base;
            beat_q <= '0;
            case_q <= '0;
        end else if (step) begin
            if (beat_last) begin
                beat_q <= '0;
                case_q <= case_q + CASE_W'(1);
            end else begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    // Offset is wide enough for case_num*VEC_LEN; only the address wraps.
    assign offset    = OFF_W'(case_q) * OFF_W'(VEC_LEN) + OFF_W'(beat_q);
    assign addr      = base_q + ADDR_W'(offset);
    assign case_idx  = case_q;
    assign beat_last = (beat_q == BEAT_W'(VEC_LEN - 1));

endmodule

// File: rtl/softmax_seq.sv
// Streams case_num vectors from BRAM through the softmax engine and back to BRAM.
// Optional SOFTMAX_SEQ_PERF_EN adds a cycle_cnt busy-cycle counter output.
module softmax_seq
    import softmax_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int CASE_W  = DEF_CASE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CASE_W-1:0] case_num,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              eng_in_ready,
    output logic              eng_in_valid,
    output logic [DATA_W-1:0] eng_in_data,
    input  logic              eng_out_valid,
    input  logic [DATA_W-1:0] eng_out_data,
    output logic              eng_out_ready
`ifdef SOFTMAX_SEQ_PERF_EN
    ,
    output logic [31:0]       cycle_cnt
`endif
);

    in_state_t         in_state, in_next;
    out_state_t        out_state, out_next;
    logic              start_acc, launch;
    logic [CASE_W-1:0] case_num_q;
    logic [CASE_W-1:0] rd_case, wr_case;
    logic              rd_last, wr_last;
    logic              capture, final_cap, last_wr_q;
    logic [ADDR_W-1:0] wr_addr_next;

    assign start_acc = start && !busy;
    assign launch    = start_acc && (case_num != '0);

    softmax_seq_addr_gen #(.ADDR_W(ADDR_W), .VEC_LEN(VEC_LEN), .CASE_W(CASE_W)) u_rd_gen (
        .clk(clk), .rst_n(rst_n), .load(launch), .step(rd_en), .base(rd_base),
        .addr(rd_addr), .case_idx(rd_case), .beat_last(rd_last)
    );

    softmax_seq_addr_gen #(.ADDR_W(ADDR_W), .VEC_LEN(VEC_LEN), .CASE_W(CASE_W)) u_wr_gen (
        .clk(clk), .rst_n(rst_n), .load(launch), .step(capture), .base(wr_base),
        .addr(wr_addr_next), .case_idx(wr_case), .beat_last(wr_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_state  <= IN_IDLE;
            out_state <= OUT_IDLE;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
        end
    end

    // Beat 0 is issued from WAIT_READY so the first read lands one cycle after start.
    always_comb begin
        in_next = in_state;
        rd_en   = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (launch) in_next = IN_WAIT_READY;
            end
            IN_WAIT_READY: begin
                if (rd_case >= case_num_q) begin
                    in_next = IN_IDLE;
                end else if (eng_in_ready) begin
                    rd_en   = 1'b1;
                    in_next = IN_SEND;
                end
            end
            IN_SEND: begin
                rd_en = 1'b1;
                if (rd_last)
                    in_next = (rd_case + CASE_W'(1) == case_num_q) ? IN_IDLE : IN_WAIT_READY;
            end
            default: in_next = IN_IDLE;
        endcase
    end

    always_comb begin
        out_next  = out_state;
        capture   = 1'b0;
        final_cap = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (launch) out_next = OUT_WAIT_VALID;
            end
            OUT_WAIT_VALID: begin
                if (eng_out_valid) begin
                    capture  = 1'b1;
                    out_next = OUT_RECV;
                end
            end
            OUT_RECV: begin
                // A stalled valid run simply holds the beat index here.
                if (eng_out_valid) begin
                    capture = 1'b1;
                    if (wr_last) begin
                        final_cap = (wr_case + CASE_W'(1) == case_num_q);
                        out_next  = final_cap ? OUT_IDLE : OUT_WAIT_VALID;
                    end
                end
            end
            default: out_next = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            eng_in_valid <= 1'b0;
            last_wr_q    <= 1'b0;
            case_num_q   <= '0;
        end else begin
            eng_in_valid <= rd_en;
            wr_en        <= capture;
            if (capture) begin
                wr_addr <= wr_addr_next;
                wr_data <= eng_out_data;
            end
            last_wr_q <= final_cap;
            done      <= last_wr_q || (start_acc && (case_num == '0));
            if (start_acc) case_num_q <= case_num;
            if (launch) busy <= 1'b1;
            else if (done) busy <= 1'b0;
        end
    end

    assign eng_in_data   = eng_in_valid ? rd_data : '0;
    assign eng_out_ready = busy;

`ifdef SOFTMAX_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) cycle_cnt <= '0;
        else if (start_acc) cycle_cnt <= '0;
        else if (busy) cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_softmax_seq.sv
// Directed bench for softmax_seq: BRAM and engine models, scoreboard of expected reads/writes.
module tb_softmax_seq;
    import softmax_pkg::*;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 12;
    localparam int VEC_LEN = 16;
    localparam int CASE_W  = 8;
    localparam int SB_W    = ADDR_W + DATA_W;
    localparam logic [DATA_W-1:0] ENG_MASK = 64'hFFFF_0000_FFFF_0000;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CASE_W-1:0] case_num;
    logic [ADDR_W-1:0] rd_base, wr_base;
    logic              busy, done, rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] wr_data, eng_in_data, eng_out_data;
    logic              eng_in_ready, eng_in_valid, eng_out_valid, eng_out_ready;
`ifdef SOFTMAX_SEQ_PERF_EN
    logic [31:0]       cycle_cnt;
`endif

    softmax_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VEC_LEN(VEC_LEN), .CASE_W(CASE_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .case_num(case_num),
        .rd_base(rd_base), .wr_base(wr_base), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .eng_in_ready(eng_in_ready), .eng_in_valid(eng_in_valid), .eng_in_data(eng_in_data),
        .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data), .eng_out_ready(eng_out_ready)
`ifdef SOFTMAX_SEQ_PERF_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- BRAM model ----------------
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [15:0] w;
        w = {4'h0, a};
        return {w, w + 16'h1000, w + 16'h2000, w + 16'h3000};
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= pattern(rd_addr);

    // ---------------- engine model ----------------
    int          in_gap = 0;
    int          out_delay = 5;
    logic [DATA_W-1:0] eng_q[$];
    int          start_q[$];
    int          in_cnt = 0, out_left = 0, gap_cnt = 0, out_beat = -1, cyc = 0;

    initial begin
        eng_in_ready  = 1'b0;
        eng_out_valid = 1'b0;
        eng_out_data  = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst_n) begin
                eng_q.delete(); start_q.delete();
                in_cnt = 0; out_left = 0; gap_cnt = 0; out_beat = -1;
                eng_out_valid = 1'b0; eng_out_data = '0; eng_in_ready = 1'b1;
            end else begin
                if (out_left > 0 && eng_q.size() > 0) begin
                    out_beat++; out_left--;
                    eng_out_valid = 1'b1; eng_out_data = eng_q.pop_front();
                end else if (start_q.size() > 0 && start_q[0] <= cyc && eng_q.size() > 0) begin
                    void'(start_q.pop_front());
                    out_beat = 0; out_left = VEC_LEN - 1;
                    eng_out_valid = 1'b1; eng_out_data = eng_q.pop_front();
                end else begin
                    out_beat = -1; eng_out_valid = 1'b0; eng_out_data = '0;
                end
                if (eng_in_valid) begin
                    eng_q.push_back(eng_in_data ^ ENG_MASK);
                    eng_in_ready = 1'b0;
                    in_cnt++;
                    if (in_cnt == VEC_LEN) begin
                        in_cnt = 0;
                        start_q.push_back(cyc + out_delay);
                        gap_cnt = in_gap;
                        if (in_gap == 0) eng_in_ready = 1'b1;
                    end
                end else if (gap_cnt > 0) begin
                    gap_cnt--;
                    if (gap_cnt == 0) eng_in_ready = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [SB_W-1:0]   exp_q[$];
    logic [ADDR_W-1:0] rd_exp_q[$];
    int   checks = 0, errors = 0, done_cnt = 0;
    bit   run_writes = 0;
    logic prev_wr = 1'b0, prev_ov = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                if (rd_exp_q.size() == 0) check("rd_unexpected", {1'b1, rd_addr}, '0);
                else check("rd_addr", rd_addr, rd_exp_q.pop_front());
            end
            if (wr_en) begin
                check("wr_after_out_valid", prev_ov, 1);
                if (exp_q.size() == 0) check("wr_unexpected", {1'b1, wr_addr, wr_data}, '0);
                else check("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                if (run_writes) begin
                    check("done_after_last_wr", prev_wr, 1);
                    check("done_wr_q_empty", exp_q.size(), 0);
                end
            end
        end
        prev_wr = wr_en;
        prev_ov = eng_out_valid && eng_out_ready;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int n, input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] wb);
        @(posedge clk); #1;
        start = 1'b1; case_num = CASE_W'(n); rd_base = rb; wr_base = wb;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue(input int n, input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] wb);
        logic [ADDR_W-1:0] ra, wa;
        for (int i = 0; i < n * VEC_LEN; i++) begin
            ra = rb + ADDR_W'(i);
            wa = wb + ADDR_W'(i);
            rd_exp_q.push_back(ra);
            exp_q.push_back({wa, pattern(ra) ^ ENG_MASK});
        end
        run_writes = (n != 0);
        done_cnt = 0;
        pulse_start(n, rb, wb);
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("rd_q_empty", rd_exp_q.size(), 0);
        check("wr_q_empty", exp_q.size(), 0);
        rd_exp_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; case_num = '0; rd_base = '0; wr_base = '0;
        idle(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_eng_in_valid", eng_in_valid, 0);
        check("rst_eng_out_ready", eng_out_ready, 0);
        check("rst_wr_addr", wr_addr, 0);
        rst_n = 1'b1;
        idle(2);

        // single case, first read one cycle after start
        issue(1, 12'd0, 12'd1024);
        @(negedge clk);
        check("first_rd_latency", rd_en, 1);
        check("busy_after_start", busy, 1);
        wait_done(300);

        // three cases with the engine stalling between bursts
        in_gap = 7;
        issue(3, 12'd0, 12'd1024);
        wait_done(600);
        idle(5);
        check("single_done_pulse", done_cnt, 1);
        in_gap = 0;

        // zero cases: immediate done, no busy, no BRAM traffic
        issue(0, 12'd5, 12'd7);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_drop", done, 0);
        idle(10);

        // read address wraps at the top of the BRAM
        issue(1, 12'd4088, 12'd2000);
        wait_done(300);

        // a second start while busy is ignored
        issue(2, 12'd200, 12'd3000);
        idle(20);
        pulse_start(5, 12'd0, 12'd0);
        check("busy_during_ignored_start", busy, 1);
        wait_done(600);
        idle(40);

        // reset during beat 5 of an output burst
        issue(1, 12'd300, 12'd3500);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (out_beat == 5) found = 1;
        end
        check("reset_beat5_reached", found, 1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_wr_en", wr_en, 0);
        check("reset_busy", busy, 0);
        check("reset_rd_en", rd_en, 0);
        check("reset_done", done, 0);
        rd_exp_q.delete();
        exp_q.delete();
        run_writes = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        issue(1, 12'd16, 12'd1100);
        wait_done(300);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
